// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// ovf is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus carry flop, LSB first, WIDTH+1 cycles/op.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] part_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic [WIDTH-1:0] part_next;

  // The full-adder cell working on the operand LSBs.
  assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Partial result is kept MSB-justified; the new bit enters at the top.
  assign part_next = {s_bit, part_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            part_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_next;
          part_q  <= part_next[WIDTH-1:1];
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            sum_q   <= part_next;
            cout_q  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB.
            ovf_q   <= carry_q ^ c_next;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Checks ovf only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] last_sum;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting from IDLE/DONE; optionally disturbs inputs mid-RUN.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic tsub, input logic [7:0] esum,
                        input logic ecout, input logic eovf, input bit perturb);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tcin;
    bus.sub   = tsub;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, " busy/done after accept"}, {30'd0, bus.busy, bus.done}, 32'b10);
    for (int i = 1; i < 8; i++) begin
      if (perturb && i == 3) begin
        bus.start = 1'b1;
        bus.a     = ~ta;
        bus.b     = 8'h00;
        bus.sub   = ~tsub;
        bus.cin   = ~tcin;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      chk({tag, " busy/done in run"}, {30'd0, bus.busy, bus.done}, 32'b10);
      if (i == 4) chk({tag, " sum holds in run"}, {24'd0, bus.sum}, {24'd0, last_sum});
    end
    tick();
    chk({tag, " busy/done at done"}, {30'd0, bus.busy, bus.done}, 32'b01);
    chk({tag, " sum"}, {24'd0, bus.sum}, {24'd0, esum});
    chk({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ecout});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("note: unknown expected ovf for %s", tag);
`endif
    last_sum = esum;
    tick();
    chk({tag, " idle after done"}, {30'd0, bus.busy, bus.done}, 32'b00);
    chk({tag, " sum held in idle"}, {24'd0, bus.sum}, {24'd0, esum});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_sum  = 8'h00;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.cin   = 1'b1;

    // Reset held two cycles with start asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset busy/done", {30'd0, bus.busy, bus.done}, 32'b00);
      chk("reset sum", {24'd0, bus.sum}, 32'h0);
      chk("reset cout", {31'd0, bus.cout}, 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset ovf", {31'd0, bus.ovf}, 32'h0);
`endif
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("idle after reset", {30'd0, bus.busy, bus.done}, 32'b00);

    run_op("add 5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    run_op("add ff+01+1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op("sub 10-20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("sub 80-01 perturbed", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);

    // start held high: results at E8 and E17.
    bus.a     = 8'h03;
    bus.b     = 8'h04;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    chk("b2b first accept", {30'd0, bus.busy, bus.done}, 32'b10);
    repeat (7) tick();
    tick();
    chk("b2b first done", {30'd0, bus.busy, bus.done}, 32'b01);
    chk("b2b first sum", {24'd0, bus.sum}, 32'h07);
    bus.a = 8'h10;
    bus.b = 8'h20;
    tick();
    chk("b2b second accept", {30'd0, bus.busy, bus.done}, 32'b10);
    chk("b2b sum holds", {24'd0, bus.sum}, 32'h07);
    repeat (7) tick();
    chk("b2b not yet done", {30'd0, bus.busy, bus.done}, 32'b10);
    bus.start = 1'b0;
    tick();
    chk("b2b second done", {30'd0, bus.busy, bus.done}, 32'b01);
    chk("b2b second sum", {24'd0, bus.sum}, 32'h30);
    tick();
    chk("b2b idle", {30'd0, bus.busy, bus.done}, 32'b00);

    // Reset on the 4th RUN edge aborts.
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("mid reset busy/done", {30'd0, bus.busy, bus.done}, 32'b00);
    chk("mid reset sum", {24'd0, bus.sum}, 32'h0);
    chk("mid reset cout", {31'd0, bus.cout}, 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("mid reset ovf", {31'd0, bus.ovf}, 32'h0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle after mid reset", {30'd0, bus.busy, bus.done}, 32'b00);
    last_sum = 8'h00;
    run_op("add 01+01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, behind a start/busy/done handshake. It is the multi-bit, sequential generation of the lab full adder and sits between switch/register inputs and the LED/7-segment display logic in the lab top levels.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = add (a + b + cin), 1 = subtract (a + ~b + 1, cin ignored); captured with start.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry in for add; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result register; holds the last completed result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when bit counter == WIDTH-1.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Accepting edge:
  - Latch a into a shift register, and b (or ~b when sub=1) into a second shift register.
  - Load the carry flop with cin (add) or 1 (sub).
  - Clear the bit counter and the internal partial-result shift register.
- Each RUN edge:
  - Compute s = a0 ^ b0 ^ c and c' = a0&b0 | a0&c | b0&c on the shift-register LSBs.
  - Shift s into the partial-result MSB (shift right), shift both operand registers right, store c' into the carry flop, and increment the counter.
- On the final RUN edge, the full partial result plus the final bit loads sum, c' loads cout, and state goes to DONE.
- sum/cout/ovf change only on that edge; they hold through IDLE and through any following RUN.
- start in RUN is ignored. Operand, sub and cin changes after the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE and counter=0; busy=0, done=0, sum=0, cout=0, ovf=0.
- Reset mid-RUN aborts the operation with no result update.
- Latency: start accepted at edge E0 gives busy=1 after E0 through E(WIDTH). After edge E(WIDTH), sum/cout are valid and done=1 for exactly one cycle.
- Throughput: with start held high, one result every WIDTH+1 cycles. start sampled in DONE begins RUN at the next edge, so busy goes high after the same edge that drops done.
- busy and done are never high together.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - ovf = carry into MSB XOR cout, registered with sum at completion.
  - ovf resets to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with start=1 -> sum=0, cout=0, busy=0, done=0, ovf=0; no RUN entered while in reset.
- Add, WIDTH=8: a=8'h5A, b=8'h3C, cin=0, sub=0, start pulse -> busy for 8 cycles, then done pulse, sum=8'h96, cout=0, ovf=1.
- Wrap with carry in: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- Subtract: a=8'h10, b=8'h20, sub=1, cin=1 -> sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Handshake:
  - start re-pulsed and a/b changed during RUN -> ignored, result unchanged.
  - start held high -> back-to-back results every 9 cycles; sum holds its old value during the second RUN.
- Reset mid-operation: rst_n=0 on the 4th RUN edge -> IDLE with all outputs 0. A new a=8'h01, b=8'h01 operation afterwards -> sum=8'h02, cout=0.
